// File: rtl/node_2to1_arb_if.sv
// ns channel bundle: one four-phase req/ack message channel.
//
// A source raises req with src/dst/dat stable, the sink raises ack, the
// source drops req, the sink drops ack.
//
// Parameters
//   ASZ  width of src/dst address fields (default `NS_ADDRESS_SIZE)
//   DSZ  width of data field             (default `NS_DATA_SIZE)
//
// Signals
//   src, dst  message source / destination address
//   dat       message data
//   req       request, driven by the source
//   ack       acknowledge, driven by the sink
//
// Modports
//   master  message source side (drives src/dst/dat/req, reads ack)
//   slave   message sink side   (reads src/dst/dat/req, drives ack)

`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 16
`endif

interface node_2to1_arb_if #(
  parameter int ASZ = `NS_ADDRESS_SIZE,
  parameter int DSZ = `NS_DATA_SIZE
);
  logic [ASZ-1:0] src;
  logic [ASZ-1:0] dst;
  logic [DSZ-1:0] dat;
  logic           req;
  logic           ack;

  modport master (output src, output dst, output dat, output req, input ack);
  modport slave  (input src, input dst, input dat, input req, output ack);
endinterface

// File: rtl/node_2to1_arb.sv
// node_2to1_arb: two-input, one-output merge node for the ns channel network.
//
// Grants one of two four-phase input channels at a time, copies the granted
// message into a single holding register and forwards it on the output
// channel using the same four-phase protocol.
//
// Ports
//   i_clk    main clock
//   i_rst_n  asynchronous active-low reset
//   i0, i1   input channels (slave side of node_2to1_arb_if)
//   o0       output channel (master side of node_2to1_arb_if)
//   o_busy   high whenever the FSM is not IDLE
//   o_gnt    index of the most recently granted input (1 out of reset)
//   o_err    sticky protocol-error flag
//
// Build option
//   NS_ARB_FIXED_PRIO_EN  when defined, ties always go to input 0;
//                         otherwise ties alternate round-robin on o_gnt.
//
// State    | meaning
// ---------+------------------------------------------------------------
// IDLE     | no transfer; grant the next pending input
// ACK_IN   | winner's ack high, waiting for winner to drop req
// SEND     | o0_req high with the held message, waiting for o0_ack
// RET      | o0_req low, waiting for o0_ack to return low

`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 16
`endif

module node_2to1_arb #(
  parameter int ASZ = `NS_ADDRESS_SIZE,
  parameter int DSZ = `NS_DATA_SIZE
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  node_2to1_arb_if.slave  i0,
  node_2to1_arb_if.slave  i1,
  node_2to1_arb_if.master o0,
  output logic            o_busy,
  output logic            o_gnt,
  output logic            o_err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACK_IN = 2'd1,
    ST_SEND   = 2'd2,
    ST_RET    = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     ack_q, ack_d;
  logic           oreq_q, oreq_d;
  logic [ASZ-1:0] src_q, src_d;
  logic [ASZ-1:0] dst_q, dst_d;
  logic [DSZ-1:0] dat_q, dat_d;
  logic           gnt_q, gnt_d;
  logic           err_q, err_d;
  logic           busy_q, busy_d;

  logic [1:0]     pend;
  logic           win;
  logic           win_req;

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    oreq_d  = oreq_q;
    src_d   = src_q;
    dst_d   = dst_q;
    dat_d   = dat_q;
    gnt_d   = gnt_q;
    err_d   = err_q;

    // A request only counts as new while its ack is low.
    pend = {i1.req & ~ack_q[1], i0.req & ~ack_q[0]};

`ifdef NS_ARB_FIXED_PRIO_EN
    win = ~pend[0];
`else
    // Tie goes to the input that did not win last time.
    win = (pend == 2'b11) ? ~gnt_q : pend[1];
`endif

    // gnt_q names the input currently being served once we leave IDLE.
    win_req = gnt_q ? i1.req : i0.req;

    case (state_q)
      ST_IDLE: begin
        if (|pend) begin
          ack_d   = win ? 2'b10 : 2'b01;
          src_d   = win ? i1.src : i0.src;
          dst_d   = win ? i1.dst : i0.dst;
          dat_d   = win ? i1.dat : i0.dat;
          gnt_d   = win;
          state_d = ST_ACK_IN;
        end
      end
      ST_ACK_IN: begin
        if (!win_req) begin
          ack_d   = 2'b00;
          oreq_d  = 1'b1;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (o0.ack) begin
          oreq_d  = 1'b0;
          state_d = ST_RET;
        end
      end
      ST_RET: begin
        if (!o0.ack) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Output ack before we asked, or the served input re-requesting before
    // the node has returned to IDLE to re-grant it.
    if ((state_q == ST_IDLE || state_q == ST_ACK_IN) && o0.ack) begin
      err_d = 1'b1;
    end
    if ((state_q == ST_SEND || state_q == ST_RET) && win_req) begin
      err_d = 1'b1;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      ack_q   <= 2'b00;
      oreq_q  <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      dat_q   <= '0;
      gnt_q   <= 1'b1;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      oreq_q  <= oreq_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      dat_q   <= dat_d;
      gnt_q   <= gnt_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign i0.ack = ack_q[0];
  assign i1.ack = ack_q[1];
  assign o0.req = oreq_q;
  assign o0.src = src_q;
  assign o0.dst = dst_q;
  assign o0.dat = dat_q;
  assign o_busy = busy_q;
  assign o_gnt  = gnt_q;
  assign o_err  = err_q;

endmodule

// File: tb/tb_node_2to1_arb.sv
// Self-checking bench for node_2to1_arb: directed scenarios with
// hand-computed expectations; a responsive sink model records every
// message presented on the output channel.

module tb_node_2to1_arb;
  localparam int ASZ = 8;
  localparam int DSZ = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, gnt, err;

  node_2to1_arb_if #(.ASZ(ASZ), .DSZ(DSZ)) i0_if ();
  node_2to1_arb_if #(.ASZ(ASZ), .DSZ(DSZ)) i1_if ();
  node_2to1_arb_if #(.ASZ(ASZ), .DSZ(DSZ)) o0_if ();

  node_2to1_arb #(.ASZ(ASZ), .DSZ(DSZ)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i0      (i0_if),
    .i1      (i1_if),
    .o0      (o0_if),
    .o_busy  (busy),
    .o_gnt   (gnt),
    .o_err   (err)
  );

  always #20 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  bit sink_en = 1'b0;

  logic [ASZ-1:0] q_src[$];
  logic [DSZ-1:0] q_dat[$];
  logic           q_gnt[$];

  // Sink: acks at the first negedge it sees req, drops ack once req is low.
  initial begin
    o0_if.ack = 1'b0;
    forever begin
      @(negedge clk);
      if (sink_en) begin
        if (o0_if.req && !o0_if.ack) begin
          q_src.push_back(o0_if.src);
          q_dat.push_back(o0_if.dat);
          q_gnt.push_back(gnt);
          o0_if.ack = 1'b1;
        end else if (!o0_if.req && o0_if.ack) begin
          o0_if.ack = 1'b0;
        end
      end
    end
  end

  function automatic logic ack_of(input int ch);
    return (ch == 0) ? i0_if.ack : i1_if.ack;
  endfunction

  task automatic clear_q;
    q_src.delete();
    q_dat.delete();
    q_gnt.delete();
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Full four-phase transaction on input ch; returns when the node is idle
  // again so that the next request is legal.
  task automatic src_send(input int ch, input logic [ASZ-1:0] s,
                          input logic [ASZ-1:0] d, input logic [DSZ-1:0] v,
                          output int lat);
    int n;
    if (ch == 0) begin
      i0_if.src = s; i0_if.dst = d; i0_if.dat = v; i0_if.req = 1'b1;
    end else begin
      i1_if.src = s; i1_if.dst = d; i1_if.dat = v; i1_if.req = 1'b1;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack_of(ch) && n < 2000);
    lat = n;
    if (!ack_of(ch)) begin
      n_checks++; n_fail++;
      $display("FAIL src%0d_ack_rise timeout: ack=0 required 1", ch);
    end
    if (ch == 0) i0_if.req = 1'b0; else i1_if.req = 1'b0;
    n = 0;
    while (ack_of(ch) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (ack_of(ch)) begin
      n_checks++; n_fail++;
      $display("FAIL src%0d_ack_fall timeout: ack=1 required 0", ch);
    end
    n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      n_checks++; n_fail++;
      $display("FAIL src%0d_idle timeout: busy=1 required 0", ch);
    end
  endtask

  task automatic test_reset;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b required 0", busy); end
    n_checks++; if (gnt !== 1'b1) begin n_fail++; $display("FAIL rst_gnt: got %b required 1", gnt); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b required 0", err); end
    n_checks++; if (o0_if.req !== 1'b0) begin n_fail++; $display("FAIL rst_o0_req: got %b required 0", o0_if.req); end
    n_checks++; if (i0_if.ack !== 1'b0 || i1_if.ack !== 1'b0) begin
      n_fail++; $display("FAIL rst_acks: got %b%b required 00", i1_if.ack, i0_if.ack);
    end
    n_checks++; if (o0_if.dat !== 16'h0 || o0_if.src !== 8'h0 || o0_if.dst !== 8'h0) begin
      n_fail++; $display("FAIL rst_hold: got %h/%h/%h required 0/0/0", o0_if.src, o0_if.dst, o0_if.dat);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_source;
    int lat;
    clear_q();
    sink_en = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      src_send(0, 8'h00, 8'h01, 16'(k), lat);
      n_checks++;
      if (lat !== 1) begin n_fail++; $display("FAIL single_ack_latency[%0d]: got %0d required 1", k, lat); end
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (q_dat.size() !== 16) begin
      n_fail++; $display("FAIL single_count: got %0d required 16", q_dat.size());
    end else begin
      for (int k = 0; k < 16; k++) begin
        n_checks++;
        if (q_dat[k] !== 16'(k) || q_src[k] !== 8'h00) begin
          n_fail++; $display("FAIL single_msg[%0d]: got src=%h dat=%h required src=00 dat=%h", k, q_src[k], q_dat[k], 16'(k));
        end
      end
    end
    n_checks++; if (o0_if.dat !== 16'd15 || o0_if.dst !== 8'h01) begin
      n_fail++; $display("FAIL single_hold: got dst=%h dat=%h required 01/000f", o0_if.dst, o0_if.dat);
    end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL single_err: got %b required 0", err); end
  endtask

  task automatic test_tie;
    int l0, l1;
    do_reset();
    clear_q();
    sink_en = 1'b1;
    @(negedge clk);
    fork
      src_send(0, 8'h00, 8'h01, 16'd5, l0);
      src_send(1, 8'h01, 8'h00, 16'd9, l1);
    join
    repeat (2) @(negedge clk);
    n_checks++;
    if (q_dat.size() !== 2) begin
      n_fail++; $display("FAIL tie_count: got %0d required 2", q_dat.size());
    end else begin
      n_checks++; if (q_dat[0] !== 16'd5 || q_gnt[0] !== 1'b0) begin
        n_fail++; $display("FAIL tie_first: got dat=%0d gnt=%b required 5/0", q_dat[0], q_gnt[0]);
      end
      n_checks++; if (q_dat[1] !== 16'd9 || q_gnt[1] !== 1'b1) begin
        n_fail++; $display("FAIL tie_second: got dat=%0d gnt=%b required 9/1", q_dat[1], q_gnt[1]);
      end
    end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL tie_err: got %b required 0", err); end
  endtask

  task automatic test_continuous;
    int n0, n1;
    logic exp_src;
    do_reset();
    clear_q();
    sink_en = 1'b1;
    @(negedge clk);
    fork
      begin
        int l;
        for (int k = 0; k < 32; k++) src_send(0, 8'h00, 8'h01, 16'(k), l);
      end
      begin
        int l;
        for (int k = 0; k < 32; k++) src_send(1, 8'h01, 8'h00, 16'(16'h100 + k), l);
      end
    join
    repeat (2) @(negedge clk);
    n_checks++;
    if (q_dat.size() !== 64) begin
      n_fail++; $display("FAIL cont_count: got %0d required 64", q_dat.size());
    end else begin
      n0 = 0;
      n1 = 0;
      for (int i = 0; i < 64; i++) begin
`ifdef NS_ARB_FIXED_PRIO_EN
        exp_src = (i >= 32);
`else
        exp_src = i[0];
`endif
        n_checks++;
        if (q_src[i] !== {7'b0, exp_src}) begin
          n_fail++; $display("FAIL cont_order[%0d]: got src=%h required %h", i, q_src[i], {7'b0, exp_src});
        end
        n_checks++;
        if (q_src[i] == 8'h00) begin
          if (q_dat[i] !== 16'(n0)) begin n_fail++; $display("FAIL cont_seq0[%0d]: got %h required %h", i, q_dat[i], 16'(n0)); end
          n0++;
        end else begin
          if (q_dat[i] !== 16'(16'h100 + n1)) begin n_fail++; $display("FAIL cont_seq1[%0d]: got %h required %h", i, q_dat[i], 16'(16'h100 + n1)); end
          n1++;
        end
      end
    end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL cont_err: got %b required 0", err); end
  endtask

  task automatic test_slow_sink;
    int l0, l1;
    clear_q();
    sink_en = 1'b0;
    @(negedge clk);
    fork
      src_send(0, 8'h00, 8'h01, 16'h00AA, l0);
      begin
        repeat (3) @(negedge clk);
        src_send(1, 8'h01, 8'h00, 16'h0055, l1);
      end
      begin
        int n;
        n = 0;
        while (!o0_if.req && n < 50) begin
          @(negedge clk);
          n++;
        end
        n_checks++; if (o0_if.req !== 1'b1) begin n_fail++; $display("FAIL slow_req_rise: got %b required 1", o0_if.req); end
        for (int c = 0; c < 10; c++) begin
          n_checks++;
          if (o0_if.req !== 1'b1 || o0_if.dat !== 16'h00AA || o0_if.src !== 8'h00 || o0_if.dst !== 8'h01) begin
            n_fail++; $display("FAIL slow_hold[%0d]: got req=%b src=%h dst=%h dat=%h required 1/00/01/00aa", c, o0_if.req, o0_if.src, o0_if.dst, o0_if.dat);
          end
          n_checks++;
          if (busy !== 1'b1 || i0_if.ack !== 1'b0 || i1_if.ack !== 1'b0) begin
            n_fail++; $display("FAIL slow_wait[%0d]: got busy=%b acks=%b%b required 1/00", c, busy, i1_if.ack, i0_if.ack);
          end
          @(negedge clk);
        end
        o0_if.ack = 1'b1;
        @(negedge clk);
        n_checks++; if (o0_if.req !== 1'b0) begin n_fail++; $display("FAIL slow_req_fall: got %b required 0", o0_if.req); end
        o0_if.ack = 1'b0;
        sink_en = 1'b1;
      end
    join
    repeat (2) @(negedge clk);
    n_checks++;
    if (q_dat.size() !== 1 || q_dat[0] !== 16'h0055) begin
      n_fail++; $display("FAIL slow_next: got n=%0d dat=%h required 1/0055", q_dat.size(), q_dat[0]);
    end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL slow_err: got %b required 0", err); end
  endtask

  task automatic test_reset_mid;
    int n, l0, l1;
    clear_q();
    sink_en = 1'b0;
    @(negedge clk);
    i0_if.src = 8'h00; i0_if.dst = 8'h01; i0_if.dat = 16'd7; i0_if.req = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!i0_if.ack && n < 20);
    i0_if.req = 1'b0;
    n = 0;
    while (!o0_if.req && n < 20) begin @(negedge clk); n++; end
    n_checks++; if (o0_if.req !== 1'b1 || o0_if.dat !== 16'd7) begin
      n_fail++; $display("FAIL mid_in_send: got req=%b dat=%0d required 1/7", o0_if.req, o0_if.dat);
    end
    i1_if.src = 8'h01; i1_if.dst = 8'h00; i1_if.dat = 16'd9; i1_if.req = 1'b1;
    @(negedge clk);
    #5 rst_n = 1'b0;
    #1;
    n_checks++; if (o0_if.req !== 1'b0) begin n_fail++; $display("FAIL mid_o0_req: got %b required 0", o0_if.req); end
    n_checks++; if (i0_if.ack !== 1'b0 || i1_if.ack !== 1'b0) begin
      n_fail++; $display("FAIL mid_acks: got %b%b required 00", i1_if.ack, i0_if.ack);
    end
    n_checks++; if (gnt !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL mid_status: got gnt=%b err=%b busy=%b required 1/0/0", gnt, err, busy);
    end
    n_checks++; if (o0_if.dat !== 16'h0) begin n_fail++; $display("FAIL mid_hold: got %h required 0000", o0_if.dat); end
    @(negedge clk);
    rst_n = 1'b1;
    i1_if.req = 1'b0;
    sink_en = 1'b1;
    fork
      src_send(0, 8'h00, 8'h01, 16'd3, l0);
      src_send(1, 8'h01, 8'h00, 16'd9, l1);
    join
    repeat (2) @(negedge clk);
    n_checks++;
    if (q_dat.size() !== 2) begin
      n_fail++; $display("FAIL mid_count: got %0d required 2", q_dat.size());
    end else begin
      n_checks++; if (q_gnt[0] !== 1'b0 || q_dat[0] !== 16'd3) begin
        n_fail++; $display("FAIL mid_tie_first: got gnt=%b dat=%0d required 0/3", q_gnt[0], q_dat[0]);
      end
      n_checks++; if (q_dat[1] !== 16'd9) begin n_fail++; $display("FAIL mid_tie_second: got %0d required 9", q_dat[1]); end
    end
  endtask

  task automatic test_spurious_ack;
    int lat;
    clear_q();
    sink_en = 1'b0;
    @(negedge clk);
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL spur_pre: got %b required 0", err); end
    o0_if.ack = 1'b1;
    @(negedge clk);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL spur_set: got %b required 1", err); end
    o0_if.ack = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL spur_sticky: got %b required 1", err); end
    sink_en = 1'b1;
    src_send(0, 8'h02, 8'h03, 16'h0021, lat);
    repeat (2) @(negedge clk);
    n_checks++;
    if (q_dat.size() !== 1 || q_dat[0] !== 16'h0021 || q_src[0] !== 8'h02) begin
      n_fail++; $display("FAIL spur_xfer: got n=%0d src=%h dat=%h required 1/02/0021", q_dat.size(), q_src[0], q_dat[0]);
    end
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL spur_hold: got %b required 1", err); end
    do_reset();
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL spur_clear: got %b required 0", err); end
  endtask

  initial begin
    i0_if.src = '0; i0_if.dst = '0; i0_if.dat = '0; i0_if.req = 1'b0;
    i1_if.src = '0; i1_if.dst = '0; i1_if.dat = '0; i1_if.req = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_source();
    test_tie();
    test_continuous();
    test_slow_sink();
    test_reset_mid();
    test_spurious_ack();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
